// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register-bank sequencer.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_LDI     = 4'd1;
  localparam logic [3:0] OP_ALU_MIN = 4'd2;
  localparam logic [3:0] OP_ALU_MAX = 4'd7;

  // Instruction field positions: opcode | dest | src1 | src2 | imm
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int DEST_MSB = 27;
  localparam int DEST_LSB = 24;
  localparam int SRC1_MSB = 23;
  localparam int SRC1_LSB = 20;
  localparam int SRC2_MSB = 19;
  localparam int SRC2_LSB = 16;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_MIN) && (op <= OP_ALU_MAX);
  endfunction

endpackage

// File: rtl/reg_bank_sequencer_if.sv
// Instruction handshake, ALU handshake and register-bank control bundle.
interface reg_bank_sequencer_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_done;
  logic [3:0]  src1_sel;
  logic [3:0]  src2_sel;
  logic [3:0]  dest_sel;
  logic        reg_wr_en;
  logic        ldr_sel;
  logic [31:0] imm_out;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic        err_illegal;
  logic        err_timeout;
  logic [15:0] retired_cnt;

  // Instruction source / ALU side
  modport master (
    output instr, instr_valid, alu_done,
    input  instr_ready, src1_sel, src2_sel, dest_sel, reg_wr_en, ldr_sel,
           imm_out, alu_start, alu_op, err_illegal, err_timeout, retired_cnt
  );

  // Sequencer side
  modport slave (
    input  instr, instr_valid, alu_done,
    output instr_ready, src1_sel, src2_sel, dest_sel, reg_wr_en, ldr_sel,
           imm_out, alu_start, alu_op, err_illegal, err_timeout, retired_cnt
  );
endinterface

// File: rtl/reg_bank_sequencer_exec_timer.sv
// EXEC-state cycle counter. Counts completed EXEC cycles; in the first EXEC
// cycle the count is 0, so the last allowed cycle is ALU_TIMEOUT-1.
module exec_timer #(
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic count_i,
  output logic first_o,
  output logic timeout_o
);

  localparam logic [7:0] LAST = 8'(ALU_TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Clear on EXEC entry, advance while in EXEC, park at the last value
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign first_o   = count_i && (cnt_q == 8'd0);
  assign timeout_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/reg_bank_sequencer.sv
// Single-issue sequencer driving a register bank and an external ALU.
//
//   state  | meaning
//   IDLE   | ready for an instruction, captures it on instr_valid
//   DECODE | classify captured opcode (NOP / LDI / ALU / illegal)
//   EXEC   | ALU launched, waiting for alu_done or timeout
//   WB     | one-cycle register-bank write, bump retired count
module reg_bank_sequencer
  import reg_bank_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  reg_bank_sequencer_if.slave  bus
);

  state_e      state_q, state_d;

  logic [3:0]  op_q;
  logic [3:0]  dest_q;
  logic [3:0]  src1_q;
  logic [3:0]  src2_q;
  logic [15:0] imm_q;
  logic        ldr_sel_q;
  logic        err_ill_q;
  logic        err_to_q;
  logic [15:0] retired_cnt_q, retired_cnt_d;

  logic        accept;
  logic        illegal_hit;
  logic        timeout_hit;
  logic        instr_ready;
  logic        reg_wr_en;
  logic        alu_start;
  logic        tmr_clear;
  logic        tmr_first;
  logic        tmr_timeout;

  exec_timer #(.ALU_TIMEOUT(ALU_TIMEOUT)) u_exec_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (tmr_clear),
    .count_i   (state_q == ST_EXEC),
    .first_o   (tmr_first),
    .timeout_o (tmr_timeout)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; alu_done beats the timeout in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (op_q == OP_NOP)       state_d = ST_IDLE;
        else if (op_q == OP_LDI)  state_d = ST_WB;
        else if (is_alu_op(op_q)) state_d = ST_EXEC;
        else                      state_d = ST_IDLE;
      end
      ST_EXEC: begin
        if (bus.alu_done)      state_d = ST_WB;
        else if (tmr_timeout)  state_d = ST_IDLE;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs and per-state event strobes
  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    reg_wr_en   = (state_q == ST_WB);
    alu_start   = tmr_first;
    accept      = instr_ready && bus.instr_valid;
    illegal_hit = (state_q == ST_DECODE) && (op_q > OP_ALU_MAX);
    timeout_hit = (state_q == ST_EXEC) && tmr_timeout && !bus.alu_done;
    tmr_clear   = (state_q == ST_DECODE) && (state_d == ST_EXEC);
  end

  // Retired-write counter wraps naturally at 16 bits
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (reg_wr_en) retired_cnt_d = retired_cnt_q + 16'd1;
  end

  // Capture registers, load-mux select, error pulses, retired count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q          <= '0;
      dest_q        <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      imm_q         <= '0;
      ldr_sel_q     <= 1'b0;
      err_ill_q     <= 1'b0;
      err_to_q      <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= bus.instr[OPC_MSB:OPC_LSB];
        dest_q <= bus.instr[DEST_MSB:DEST_LSB];
        src1_q <= bus.instr[SRC1_MSB:SRC1_LSB];
        src2_q <= bus.instr[SRC2_MSB:SRC2_LSB];
        imm_q  <= bus.instr[IMM_MSB:IMM_LSB];
      end
      if (state_q == ST_DECODE) begin
        if (state_d == ST_WB)        ldr_sel_q <= 1'b1;
        else if (state_d == ST_EXEC) ldr_sel_q <= 1'b0;
      end
      err_ill_q     <= illegal_hit;
      err_to_q      <= timeout_hit;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.reg_wr_en   = reg_wr_en;
  assign bus.alu_start   = alu_start;
  assign bus.src1_sel    = src1_q;
  assign bus.src2_sel    = src2_q;
  assign bus.dest_sel    = dest_q;
  assign bus.ldr_sel     = ldr_sel_q;
  assign bus.imm_out     = {16'h0000, imm_q};
  assign bus.alu_op      = op_q[2:0];
  assign bus.err_illegal = err_ill_q;
  assign bus.err_timeout = err_to_q;
  assign bus.retired_cnt = retired_cnt_q;

endmodule
